// File: rtl/wheel_bank_if.sv
// Interface bundling the wheel_bank write, readback and scan ports.
//   master: drives the write request, readback index and scan request; observes status/results.
//   slave : the bank itself; accepts writes and scans, returns readback and scan results.
// Signals:
//   wr_valid/wr_ready/wr_idx/wr_radius/wr_err : write request handshake and range-error pulse
//   rd_idx/rd_radius                          : combinational readback
//   scan_start/scan_ref/scan_busy/scan_done   : scan control and status
//   mismatch_mask/mismatch_cnt                : scan results
interface wheel_bank_if #(
  parameter int unsigned NUM_WHEELS = 4,
  parameter int unsigned RADIUS_W   = 2
);
  localparam int unsigned IdxW = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;
  localparam int unsigned CntW = $clog2(NUM_WHEELS + 1);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [IdxW-1:0]       wr_idx;
  logic [RADIUS_W-1:0]   wr_radius;
  logic                  wr_err;
  logic [IdxW-1:0]       rd_idx;
  logic [RADIUS_W-1:0]   rd_radius;
  logic                  scan_start;
  logic [RADIUS_W-1:0]   scan_ref;
  logic                  scan_busy;
  logic                  scan_done;
  logic [NUM_WHEELS-1:0] mismatch_mask;
  logic [CntW-1:0]       mismatch_cnt;

  modport master (
    output wr_valid, wr_idx, wr_radius, rd_idx, scan_start, scan_ref,
    input  wr_ready, wr_err, rd_radius, scan_busy, scan_done, mismatch_mask, mismatch_cnt
  );

  modport slave (
    input  wr_valid, wr_idx, wr_radius, rd_idx, scan_start, scan_ref,
    output wr_ready, wr_err, rd_radius, scan_busy, scan_done, mismatch_mask, mismatch_cnt
  );
endinterface

// File: rtl/wheel_bank.sv
// Bank of NUM_WHEELS radius registers with a sequential mismatch-scan engine.
// Ports:
//   clk   : single rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wheel_bank_if slave modport (write, readback, scan control and results)
// The scan walks one wheel per cycle comparing against a latched reference, building the
// mismatch mask and count incrementally. Registers are frozen (wr_ready low) while not idle.
module wheel_bank #(
  parameter int unsigned NUM_WHEELS = 4,
  parameter int unsigned RADIUS_W   = 2
) (
  input logic       clk,
  input logic       rst_n,
  wheel_bank_if.slave bus
);
  localparam int unsigned IdxW = (NUM_WHEELS > 1) ? $clog2(NUM_WHEELS) : 1;
  localparam int unsigned CntW = $clog2(NUM_WHEELS + 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                state_q, state_d;
  logic [RADIUS_W-1:0]   radius_q [NUM_WHEELS];
  logic [RADIUS_W-1:0]   radius_d [NUM_WHEELS];
  logic [RADIUS_W-1:0]   ref_q, ref_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [NUM_WHEELS-1:0] mask_q, mask_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  wr_err_q, wr_err_d;

  logic idle;
  logic wr_accept;
  logic scan_accept;
  logic last_wheel;

  assign idle        = (state_q == StIdle);
  assign wr_accept   = bus.wr_valid && idle;
  assign scan_accept = bus.scan_start && idle;
  assign last_wheel  = (ptr_q == IdxW'(NUM_WHEELS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.scan_start) state_d = StScan;
      StScan:  if (last_wheel)     state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.wr_ready      = idle;
    bus.scan_busy     = !idle;
    bus.scan_done     = (state_q == StDone);
    bus.wr_err        = wr_err_q;
    bus.mismatch_mask = mask_q;
    bus.mismatch_cnt  = cnt_q;
    bus.rd_radius     = '0;
    if (32'(bus.rd_idx) < NUM_WHEELS) begin
      bus.rd_radius = radius_q[bus.rd_idx];
    end
  end

  // Datapath next-state: register writes and incremental scan results
  always_comb begin
    for (int i = 0; i < NUM_WHEELS; i++) begin
      radius_d[i] = radius_q[i];
      // Out-of-range indices never match any wheel, so no register changes for them.
      if (wr_accept && (bus.wr_idx == IdxW'(i))) begin
        radius_d[i] = bus.wr_radius;
      end
    end
    wr_err_d = wr_accept && !(32'(bus.wr_idx) < NUM_WHEELS);

    ref_d  = ref_q;
    ptr_d  = ptr_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (scan_accept) begin
      ref_d  = bus.scan_ref;
      ptr_d  = '0;
      mask_d = '0;
      cnt_d  = '0;
    end else if (state_q == StScan) begin
      // Scan reads registered values, so a write landing with scan_start is seen.
      if (radius_q[ptr_q] != ref_q) begin
        mask_d[ptr_q] = 1'b1;
        cnt_d         = cnt_q + CntW'(1);
      end
      ptr_d = ptr_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WHEELS; i++) begin
        radius_q[i] <= '0;
      end
      ref_q    <= '0;
      ptr_q    <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WHEELS; i++) begin
        radius_q[i] <= radius_d[i];
      end
      ref_q    <= ref_d;
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end
endmodule

// File: tb/tb_wheel_bank.sv
// Self-checking bench for wheel_bank: 4-wheel table-driven scans with a result scoreboard,
// plus hand sequences for a 3-wheel out-of-range write, a 2-wheel same-cycle write+scan,
// and reset in the middle of a scan.
module tb_wheel_bank;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wheel_bank_if #(.NUM_WHEELS(4), .RADIUS_W(2)) if4 ();
  wheel_bank_if #(.NUM_WHEELS(3), .RADIUS_W(2)) if3 ();
  wheel_bank_if #(.NUM_WHEELS(2), .RADIUS_W(2)) if2 ();

  wheel_bank #(.NUM_WHEELS(4), .RADIUS_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  wheel_bank #(.NUM_WHEELS(3), .RADIUS_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  wheel_bank #(.NUM_WHEELS(2), .RADIUS_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // mode: 0 plain, 1 hold a write to wheel 2 during the scan, 2 hold scan_start through DONE
  typedef struct packed {
    logic [3:0][1:0] radii;
    logic [1:0]      ref_r;
    logic [3:0]      mask;
    logic [2:0]      cnt;
    logic [1:0]      mode;
  } vec_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  // Scoreboard: every scan_done pops the result expected when that scan was started.
  always @(negedge clk) begin
    if (if4.scan_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got scan_done=1, required no pending scan (t=%0t)",
                 $time);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_mask", 32'(if4.mismatch_mask), 32'(sb_e.mask));
        check("sb_cnt", 32'(if4.mismatch_cnt), 32'(sb_e.cnt));
      end
    end
  end

  task automatic write4(input logic [1:0] idx, input logic [1:0] val);
    check("wr_ready_idle", 32'(if4.wr_ready), 32'd1);
    if4.wr_valid  = 1'b1;
    if4.wr_idx    = idx;
    if4.wr_radius = val;
    @(negedge clk);
    if4.wr_valid = 1'b0;
  endtask

  task automatic read4(input string name, input logic [1:0] idx, input logic [1:0] exp);
    if4.rd_idx = idx;
    #1;
    check(name, 32'(if4.rd_radius), 32'(exp));
  endtask

  // Called at a negedge in IDLE; the following posedge is edge T.
  task automatic run_scan4(input logic [1:0] ref_v, input logic [3:0] m, input logic [2:0] c,
                           input logic [1:0] mode);
    if4.scan_start = 1'b1;
    if4.scan_ref   = ref_v;
    sb_q.push_back({m, c});
    @(negedge clk);  // T+1
    if (mode != 2'd2) if4.scan_start = 1'b0;
    if (mode == 2'd1) begin
      if4.wr_valid  = 1'b1;
      if4.wr_idx    = 2'd2;
      if4.wr_radius = 2'd0;
    end
    check("scan_mask_cleared", 32'(if4.mismatch_mask), 32'd0);
    check("scan_cnt_cleared", 32'(if4.mismatch_cnt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      check("scan_busy", 32'(if4.scan_busy), 32'd1);
      check("scan_done_early", 32'(if4.scan_done), 32'd0);
      check("scan_wr_ready", 32'(if4.wr_ready), 32'd0);
      @(negedge clk);
    end
    // T+5
    check("done_busy", 32'(if4.scan_busy), 32'd1);
    check("done_pulse", 32'(if4.scan_done), 32'd1);
    check("done_wr_ready", 32'(if4.wr_ready), 32'd0);
    @(negedge clk);  // T+6
    if4.scan_start = 1'b0;
    if4.wr_valid   = 1'b0;
    check("after_busy", 32'(if4.scan_busy), 32'd0);
    check("after_done", 32'(if4.scan_done), 32'd0);
    check("after_wr_ready", 32'(if4.wr_ready), 32'd1);
    check("hold_mask", 32'(if4.mismatch_mask), 32'(m));
    check("hold_cnt", 32'(if4.mismatch_cnt), 32'(c));
    @(negedge clk);  // T+7
    check("no_restart_busy", 32'(if4.scan_busy), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{radii: {2'd3, 2'd3, 2'd3, 2'd3}, ref_r: 2'd3, mask: 4'b0000, cnt: 3'd0, mode: 2'd0};
    vecs[1] = '{radii: {2'd3, 2'd1, 2'd3, 2'd3}, ref_r: 2'd3, mask: 4'b0100, cnt: 3'd1, mode: 2'd1};
    vecs[2] = '{radii: {2'd3, 2'd2, 2'd1, 2'd0}, ref_r: 2'd2, mask: 4'b1011, cnt: 3'd3, mode: 2'd0};
    vecs[3] = '{radii: {2'd1, 2'd1, 2'd1, 2'd1}, ref_r: 2'd0, mask: 4'b1111, cnt: 3'd4, mode: 2'd2};
    vecs[4] = '{radii: {2'd2, 2'd0, 2'd2, 2'd0}, ref_r: 2'd2, mask: 4'b0101, cnt: 3'd2, mode: 2'd0};

    rst_n = 1'b0;
    if4.wr_valid = 1'b0; if4.wr_idx = '0; if4.wr_radius = '0; if4.rd_idx = '0;
    if4.scan_start = 1'b0; if4.scan_ref = '0;
    if3.wr_valid = 1'b0; if3.wr_idx = '0; if3.wr_radius = '0; if3.rd_idx = '0;
    if3.scan_start = 1'b0; if3.scan_ref = '0;
    if2.wr_valid = 1'b0; if2.wr_idx = '0; if2.wr_radius = '0; if2.rd_idx = '0;
    if2.scan_start = 1'b0; if2.scan_ref = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(if4.scan_busy), 32'd0);
    check("rst_done", 32'(if4.scan_done), 32'd0);
    check("rst_wr_err", 32'(if4.wr_err), 32'd0);
    check("rst_mask", 32'(if4.mismatch_mask), 32'd0);
    check("rst_cnt", 32'(if4.mismatch_cnt), 32'd0);
    check("rst_wr_ready", 32'(if4.wr_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) read4("rst_radius", 2'(i), 2'd0);

    // Table-driven scans on the 4-wheel bank
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) write4(2'(i), vecs[v].radii[i]);
      check("wr_err_in_range", 32'(if4.wr_err), 32'd0);
      for (int i = 0; i < 4; i++) read4("readback", 2'(i), vecs[v].radii[i]);
      run_scan4(vecs[v].ref_r, vecs[v].mask, vecs[v].cnt, vecs[v].mode);
      for (int i = 0; i < 4; i++) read4("readback_post_scan", 2'(i), vecs[v].radii[i]);
    end

    // 3-wheel bank: out-of-range write index 3
    for (int i = 0; i < 3; i++) begin
      if3.wr_valid  = 1'b1;
      if3.wr_idx    = 2'(i);
      if3.wr_radius = 2'd2;
      @(negedge clk);
    end
    if3.wr_valid = 1'b0;
    check("n3_wr_err_valid", 32'(if3.wr_err), 32'd0);
    if3.wr_valid  = 1'b1;
    if3.wr_idx    = 2'd3;
    if3.wr_radius = 2'd1;
    @(negedge clk);
    if3.wr_valid = 1'b0;
    check("n3_wr_err_pulse", 32'(if3.wr_err), 32'd1);
    @(negedge clk);
    check("n3_wr_err_clear", 32'(if3.wr_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if3.rd_idx = 2'(i);
      #1;
      check("n3_readback", 32'(if3.rd_radius), (i < 3) ? 32'd2 : 32'd0);
    end

    // 2-wheel bank: write and scan_start in the same cycle
    if2.wr_valid  = 1'b1;
    if2.wr_idx    = 1'b1;
    if2.wr_radius = 2'd0;
    @(negedge clk);
    if2.wr_idx     = 1'b0;
    if2.wr_radius  = 2'd1;
    if2.scan_start = 1'b1;
    if2.scan_ref   = 2'd1;
    @(negedge clk);  // T+1
    if2.wr_valid   = 1'b0;
    if2.scan_start = 1'b0;
    check("n2_busy_t1", 32'(if2.scan_busy), 32'd1);
    check("n2_done_t1", 32'(if2.scan_done), 32'd0);
    @(negedge clk);  // T+2
    check("n2_done_t2", 32'(if2.scan_done), 32'd0);
    @(negedge clk);  // T+3
    check("n2_done_t3", 32'(if2.scan_done), 32'd1);
    check("n2_mask", 32'(if2.mismatch_mask), 32'b10);
    check("n2_cnt", 32'(if2.mismatch_cnt), 32'd1);
    @(negedge clk);  // T+4
    check("n2_wr_ready_t4", 32'(if2.wr_ready), 32'd1);
    check("n2_busy_t4", 32'(if2.scan_busy), 32'd0);
    if2.rd_idx = 1'b0;
    #1;
    check("n2_readback0", 32'(if2.rd_radius), 32'd1);

    // Reset two cycles into a 4-wheel scan (radii are {0,2,0,2} for wheels 0..3)
    @(negedge clk);
    if4.scan_start = 1'b1;
    if4.scan_ref   = 2'd3;
    @(negedge clk);  // T+1
    if4.scan_start = 1'b0;
    @(negedge clk);  // T+2
    check("mid_mask_partial", 32'(if4.mismatch_mask), 32'b0001);
    check("mid_cnt_partial", 32'(if4.mismatch_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(if4.scan_busy), 32'd0);
    check("mid_rst_mask", 32'(if4.mismatch_mask), 32'd0);
    check("mid_rst_cnt", 32'(if4.mismatch_cnt), 32'd0);
    check("mid_rst_done", 32'(if4.scan_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_ready", 32'(if4.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) read4("mid_rst_radius", 2'(i), 2'd0);
    repeat (8) @(negedge clk);
    check("mid_rst_no_done", 32'(if4.scan_done), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wheel_bank.md
Name: wheel_bank

Overview:
- Parametrised bank of per-wheel radius registers for vehicle models; one block replaces N hand-placed single-wheel instances.
- Writes go through a valid/ready port, and the values can be read back.
- A sequential scan engine compares every wheel against a reference radius and reports a mismatch mask and a mismatch count.
- Instantiated once per vehicle, e.g. NUM_WHEELS=2 for a motorcycle, 4 for a car, 8 for a truck, under a top-level garage.

Parameters:
- NUM_WHEELS, 4, number of wheel registers; legal range 1..64.
- RADIUS_W, 2, width of each radius value in bits; legal range 1..16.
- IDX_W, derived as max(1, $clog2(NUM_WHEELS)), wheel index width; not overridden by the user.
- CNT_W, derived as $clog2(NUM_WHEELS+1), mismatch count width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted this cycle.
- wr_idx  in  IDX_W  target wheel index.
- wr_radius  in  RADIUS_W  radius to store.
- wr_err  out  1  one-cycle pulse: accepted write had wr_idx >= NUM_WHEELS.
- rd_idx  in  IDX_W  readback index.
- rd_radius  out  RADIUS_W  combinational readback of reg[rd_idx]; 0 if rd_idx >= NUM_WHEELS.
- scan_start  in  1  request a scan.
- scan_ref  in  RADIUS_W  reference radius, sampled with scan_start.
- scan_busy  out  1  scan engine not idle.
- scan_done  out  1  one-cycle pulse at scan completion.
- mismatch_mask  out  NUM_WHEELS  bit i set when reg[i] != reference.
- mismatch_cnt  out  CNT_W  popcount of mismatch_mask.

Behaviour:
- Reset, asynchronous on rst_n low: all radius regs = 0, so no X radii; FSM = IDLE; wr_err = 0, scan_done = 0, mismatch_mask = 0, mismatch_cnt = 0, scan_busy = 0.
- wr_ready = (state == IDLE); during a scan the registers are frozen.
- Write accepted when wr_valid && wr_ready. The register updates at that edge and is visible on rd_radius the next cycle.
- Out-of-range index: the write is accepted but no register changes, and wr_err pulses for 1 cycle after the accepting edge.
- FSM states IDLE, SCAN, DONE:
  - IDLE -> SCAN when scan_start = 1. At that edge: latch scan_ref into ref_q, clear ptr, mismatch_mask and mismatch_cnt.
  - SCAN examines wheel ptr each cycle. If reg[ptr] != ref_q it sets mask[ptr] and increments the count; ptr then increments.
  - SCAN -> DONE after ptr == NUM_WHEELS-1 is examined. SCAN lasts exactly NUM_WHEELS cycles.
  - DONE asserts scan_done for 1 cycle, then -> IDLE.
- scan_busy = (state != IDLE).
- Timing for scan_start sampled at edge T:
  - scan_busy is high from cycle T+1 through T+1+NUM_WHEELS.
  - scan_done is high in cycle T+1+NUM_WHEELS.
  - wr_ready returns in cycle T+2+NUM_WHEELS.
- scan_start while busy is ignored; there is no queuing.
- Write and scan_start in the same IDLE cycle: both are accepted. The write lands at the same edge, so the scan sees the new value.
- Back-to-back: scan_start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.
- mismatch_mask and mismatch_cnt update incrementally during SCAN, are final when scan_done is high, and hold until the next scan_start.
- mismatch_cnt never exceeds NUM_WHEELS, and its width holds NUM_WHEELS exactly.
- Reset mid-scan: immediate return to the reset values; scan_done is not pulsed and the partial results are discarded.
- rd_radius is valid at all times, including during a scan.

Test Plan:
1. NUM_WHEELS=4, RADIUS_W=2: reset, then read idx 0..3 -> rd_radius=0 for every wheel; every output at its reset value.
2. Write radius 3 to wheels 0..3, then scan_start with scan_ref=3 -> busy for 5 cycles, scan_done at T+5, mismatch_mask=4'b0000, mismatch_cnt=0.
3. Set wheel 2 to 1, then scan with scan_ref=3 -> mismatch_mask=4'b0100, mismatch_cnt=1. Hold wr_valid during the scan -> wr_ready=0 and the registers are unchanged.
4. Write to wr_idx=5 with NUM_WHEELS=4 and IDX_W=2 → the index is not reachable, so rerun with NUM_WHEELS=3, wr_idx=3. Required response: wr_err pulses once and no register changes.
5. NUM_WHEELS=2: write wheel 0=1 and pulse scan_start with scan_ref=1 in the same cycle, with wheel 1=0 -> mismatch_mask=2'b10, mismatch_cnt=1, scan_done at T+3.
6. Drop rst_n two cycles into a scan -> outputs clear immediately, no scan_done pulse, radii=0, wr_ready=1 after reset is released.
